// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the pipeline load/store port.
//   Accepts one request at a time, waits LATENCY cycles, then commits the store or
//   returns load data alongside a single-cycle resp_valid pulse.
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   req_valid/we      request strobe, 1 = store / 0 = load
//   req_addr/wdata    64-bit byte address and store data
//   req_ready         request can be accepted this cycle
//   resp_valid        one-cycle completion pulse
//   resp_rdata/err    load data and fault flag, zero outside resp_valid
//   busy              request in flight, stalls the MEM stage
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [63:0]     mem_q [DEPTH];
    logic [63:0]     mem_d [DEPTH];
    logic            accept, enter_resp, op_we, op_err;
    logic [63:0]     op_addr, op_wdata;
    logic [AW-1:0]   op_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = (LATENCY == 1) ? RESP : WAIT;
            cnt_d   = CW'(LATENCY - 1);
        end else if (state_q == WAIT) begin
            state_d = (cnt_q == CW'(1)) ? RESP : WAIT;
            cnt_d   = cnt_q - CW'(1);
        end else begin
            state_d = IDLE;
        end
    end

    // With LATENCY==1 the edge entering RESP is the accept edge itself, so the
    // operation comes straight from the request port rather than the latches.
    always_comb begin
        enter_resp = state_d == RESP;
        op_we      = (state_q == WAIT) ? we_q    : req_we;
        op_addr    = (state_q == WAIT) ? addr_q  : req_addr;
        op_wdata   = (state_q == WAIT) ? wdata_q : req_wdata;
        op_idx     = op_addr[AW+2:3];
        op_err     = (|op_addr[2:0]) | (|op_addr[63:AW+3]);
        mem_d      = mem_q;
        if (enter_resp && op_we && !op_err) mem_d[op_idx] = op_wdata;
        rdata_d    = (enter_resp && !op_we && !op_err) ? mem_q[op_idx] : '0;
        err_d      = enter_resp && op_err;
    end

    always_comb begin
        accept     = req_valid && req_ready;
        req_ready  = state_q != WAIT;
        busy       = state_q == WAIT;
        resp_valid = state_q == RESP;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end
endmodule
